// File: rtl/div_seq_pkg.sv
// Shared constants and types for the sequential divider: ALU op codes,
// FSM state encodings and the iteration count.
package div_seq_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // True for either divide flavour; everything else is ignored by the divider.
    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left by one, trial-subtract
// the divisor from the widened remainder and keep the difference when it
// does not borrow. The remainder stays below the divisor between steps, so a
// WIDTH+1 bit subtract is enough and its top bit is the borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] rq,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] rq_nxt
);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   diff;
    logic             borrow;

    assign rem    = rq[2*WIDTH-1:WIDTH];
    assign quo    = rq[WIDTH-1:0];
    assign rsh    = {rem, quo[WIDTH-1]};
    assign diff   = rsh - {1'b0, divisor};
    assign borrow = diff[WIDTH];

    assign rq_nxt = {borrow ? rsh[WIDTH-1:0] : diff[WIDTH-1:0],
                     quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_seq.sv
// Sequential DIV/DIVU unit for the EX stage. Runs a 32-step restoring divide
// on operand magnitudes, stalls the front of the pipe while it works, then
// pulses hilo_we for one cycle with the sign-corrected quotient/remainder.
// flush annuls whatever is in flight.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_i,
    input  logic [7:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             stall_o,
    output logic             busy_o,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(DIV_ITER);

    div_state_e           state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     rem, quo, dvsr;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [WIDTH-1:0]     hi_fix, lo_fix;
    logic [2*WIDTH-1:0]   rq_nxt;
    logic                 sign_q, sign_r;
    logic                 start, is_signed;
    logic                 neg_a, neg_b;

    assign start     = valid_i & ~flush & is_div_op(alucontrol);
    assign is_signed = (alucontrol == EXE_DIV_OP);
    assign neg_a     = is_signed & srca[WIDTH-1];
    assign neg_b     = is_signed & srcb[WIDTH-1];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rq      ({rem, quo}),
        .divisor (dvsr),
        .rq_nxt  (rq_nxt)
    );

    // Two's complement fix-up; modulo 2^WIDTH so 0x80000000 negates to itself.
    assign lo_fix = sign_q ? -quo : quo;
    assign hi_fix = sign_r ? -rem : rem;

    // While the write strobe is up the fresh result is shown directly,
    // afterwards the committed copy is held.
    assign lo_o = hilo_we ? lo_fix : lo_q;
    assign hi_o = hilo_we ? hi_fix : hi_q;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and control outputs; flush overrides everything.
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        hilo_we   = 1'b0;
        busy_o    = (state != DIV_IDLE);
        case (state)
            DIV_IDLE: begin
                if (start) begin
                    state_nxt = DIV_CALC;
                    stall_o   = 1'b1;
                end
            end
            DIV_CALC: begin
                stall_o = 1'b1;
                if (cnt == CW'(DIV_ITER - 1)) state_nxt = DIV_DONE;
            end
            DIV_DONE: begin
                hilo_we   = 1'b1;
                state_nxt = DIV_IDLE;
            end
            default: state_nxt = DIV_IDLE;
        endcase
        if (flush) begin
            state_nxt = DIV_IDLE;
            stall_o   = 1'b0;
            hilo_we   = 1'b0;
        end
    end

    // Operand capture on accept, one restoring step per CALC cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            rem    <= '0;
            quo    <= neg_a ? -srca : srca;
            dvsr   <= neg_b ? -srcb : srcb;
            cnt    <= '0;
            sign_q <= neg_a ^ neg_b;
            sign_r <= neg_a;
        end else if (state == DIV_CALC) begin
            rem <= rq_nxt[2*WIDTH-1:WIDTH];
            quo <= rq_nxt[WIDTH-1:0];
            cnt <= cnt + CW'(1);
        end
    end

    // Commit the result when the write strobe actually fires.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_we) begin
            hi_q <= hi_fix;
            lo_q <= lo_fix;
        end
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential divide controller for the MIPS EX stage. Accepts a DIV/DIVU from the ALU decode path and runs a 32-iteration restoring division on operand magnitudes. Holds the pipeline with a stall until the result is ready, then writes HI/LO through a single-cycle write-enable pulse. An exception flush annuls any in-flight division.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk` in, 1: clock, rising edge.
- `resetn` in, 1: reset, asynchronous, active-low.
- `valid_i` in, 1: EX stage holds a valid, non-flushed instruction.
- `alucontrol` in, 8: decoded ALU op from defines.vh; only `EXE_DIV_OP` and `EXE_DIVU_OP` are acted on.
- `srca` in, WIDTH: dividend (rs).
- `srcb` in, WIDTH: divisor (rt).
- `flush` in, 1: exception/annul; aborts the current operation.
- `stall_o` out, 1: hold IF..EX; combinational.
- `busy_o` out, 1: state != IDLE.
- `hilo_we` out, 1: one-cycle HI/LO write strobe.
- `hi_o` out, WIDTH: remainder.
- `lo_o` out, WIDTH: quotient.

## Operation
- States: IDLE, CALC, DONE (encodings in defines.vh).
- Start condition: `start = valid_i & ~flush & (alucontrol==EXE_DIV_OP | alucontrol==EXE_DIVU_OP)`.
- IDLE + start:
  - Latch `|srca|` and `|srcb|`; magnitudes apply for DIV only, DIVU latches raw values.
  - Latch `sign_q = srca[31]^srcb[31]` and `sign_r = srca[31]` (DIV only, else 0).
  - Clear the partial remainder and the counter, then go to CALC.
- CALC: each cycle performs one restoring step.
  - `{r,q} <<= 1`.
  - If `r >= divisor`, then `r -= divisor` and `q[0] = 1`.
  - Counter runs 0..31; at count 31 go to DONE.
- DONE:
  - Apply the sign fix: `lo_o = sign_q ? -q : q`, `hi_o = sign_r ? -r : r`.
  - Assert `hilo_we`.
  - Always return to IDLE; IDLE does not re-sample in the DONE cycle.
- `stall_o = (IDLE & start) | CALC`. It is low in DONE, so the divide instruction leaves EX in that same cycle.
- `flush` in any state: go to IDLE next edge. `hilo_we` is forced 0 in that cycle, and `stall_o` is 0 while `flush` is high.
- Divide by zero is not trapped. The algorithm gives:
  - DIVU: LO=0xFFFFFFFF, HI=srca.
  - DIV: LO = srca<0 ? 1 : 0xFFFFFFFF, HI=srca.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Arithmetic:
  - The subtract is WIDTH+1 bits wide; its borrow selects restore.
  - Negation is two's complement modulo 2^WIDTH.

## Timing
- Reset values: state=IDLE, counter=0, hi_o=0, lo_o=0, hilo_we=0, stall_o=0, busy_o=0.
- Cycle numbering:
  - Cycle 0: accept; `stall_o`=1 combinationally.
  - Cycles 1..32: CALC; `stall_o`=1.
  - Cycle 33: DONE; `hilo_we`=1, `stall_o`=0.
- Stall is asserted for exactly 33 cycles per division.
- Back-to-back divides: the second is accepted in cycle 34, the first IDLE cycle.
- `hi_o`/`lo_o` hold their value until the next DONE.
- `flush` during CALC at cycle k: state is IDLE at cycle k+1. A new start is accepted at k+1.
- `flush` coincident with DONE: no write occurs.
- `resetn` low mid-operation: immediate asynchronous return to reset values. No write occurs.

## Structure
- defines.vh (shared) holds:
  - `EXE_DIV_OP` and `EXE_DIVU_OP`, already present.
  - State encodings `DIV_IDLE`, `DIV_CALC`, `DIV_DONE`.
  - `DIV_ITER` = 32.
- One combinational sub-module, `div_step`: one restoring iteration. Inputs are `{r,q}` and the divisor; outputs are the next `{r,q}`.
- `div_seq` owns the FSM, counter, operand and sign registers, and the output fix-up.

## Test plan
- DIVU 7/2 → cycle 33: hilo_we=1, LO=3, HI=1. `stall_o` high in cycles 0..32 and low in cycle 33.
- DIV −7/2 (0xFFFFFFF9 / 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 7/−2 → LO=0xFFFFFFFD, HI=1.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIVU 100/7, assert `flush` in cycle 10:
  - No hilo_we; state IDLE and stall_o=0 in cycle 11; HI/LO unchanged.
  - DIVU 9/3 started in cycle 11 → LO=3, HI=0 in cycle 44.
- Two back-to-back DIVU ops (20/6 then 15/4) → hilo_we in cycles 33 and 67 with (LO,HI)=(3,2) then (3,3).
- Deassert `resetn` in cycle 15 of a DIV → outputs immediately 0, busy_o=0. After release a fresh DIVU 8/2 gives LO=4, HI=0.
